fetch_unit: RTL and testbench

- Program-counter / instruction-fetch stage that drives the InstAddress input of the instruction ROM.
- Sequences through the program after a Start pulse.
- Applies relative branches and LUT-based absolute jumps requested by decode, and honours stalls.
- Stops on Halt and reports Done to the testbench/top level.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/jump_lut.sv | 26 ++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction-fetch stage.
//            - fetch_state_t : FSM state encoding (IDLE / RUN / HALTED)
//            - FETCH_A / FETCH_OFFW / FETCH_L : default widths
//            - JUMP_LUT : absolute jump-target table, entry i = 2*i mod 2**A
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int FETCH_A    = 4;  // instruction address width
  localparam int FETCH_OFFW = 4;  // signed branch offset width
  localparam int FETCH_L    = 3;  // jump-LUT index width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [FETCH_A-1:0] JUMP_LUT [2**FETCH_L] = '{
    4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14
  };

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/jump_lut.sv
`default_nettype none
// ============================================================================
// Module   : jump_lut
// Purpose  : Combinational lookup of an absolute jump target.
// Ports    : JumpIdx (in, L bits)  - table index from decode
//            Target  (out, A bits) - jump destination address
// Revision : 1.0  initial release
// ============================================================================
module jump_lut
  import fetch_pkg::*;
#(
  parameter int A = FETCH_A,
  parameter int L = FETCH_L
) (
  input  logic [L-1:0] JumpIdx,
  output logic [A-1:0] Target
);

  logic [FETCH_A-1:0] entry_w;

  // The table lives in the package at its native widths; resize at the edge.
  assign entry_w = JUMP_LUT[FETCH_L'(JumpIdx)];
  assign Target  = A'(entry_w);

endmodule : jump_lut
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Program counter / instruction-fetch stage. Sequences through the
//            program after Start, applies relative branches and LUT jumps,
//            honours Stall, stops on Halt and pulses Done.
// Ports    : CLK, Reset (sync, active-high)
//            Start, StartAddr           - begin/restart execution
//            Halt, Stall                - decode control
//            BranchEn, BranchOffset     - relative branch (signed offset)
//            JumpEn, JumpIdx            - absolute jump via LUT
//            InstAddress                - registered PC to the ROM
//            Running, Done, Wrapped     - registered status
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int A    = FETCH_A,
  parameter int OFFW = FETCH_OFFW,
  parameter int L    = FETCH_L
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic [A-1:0]    StartAddr,
  input  logic            Halt,
  input  logic            Stall,
  input  logic            BranchEn,
  input  logic [OFFW-1:0] BranchOffset,
  input  logic            JumpEn,
  input  logic [L-1:0]    JumpIdx,
  output logic [A-1:0]    InstAddress,
  output logic            Running,
  output logic            Done,
  output logic            Wrapped
);

  fetch_state_t state_q;
  logic [A-1:0] pc_q;
  logic [A-1:0] pc_d;
  logic         wrap_d;
  logic         running_q;
  logic         done_q;
  logic         wrapped_q;
  logic [A-1:0] jump_target_w;
  logic [A-1:0] branch_off_w;

  jump_lut #(
    .A (A),
    .L (L)
  ) u_jump_lut (
    .JumpIdx (JumpIdx),
    .Target  (jump_target_w)
  );

  // Sign-extend the offset to address width; the add then wraps mod 2**A.
  assign branch_off_w = A'($signed(BranchOffset));

  // Next PC while in RUN and not halting. Only the plain increment can
  // raise the wrap flag; branches that cross zero do not.
  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (Stall) begin
      pc_d = pc_q;
    end else if (JumpEn) begin
      pc_d = jump_target_w;
    end else if (BranchEn) begin
      pc_d = pc_q + branch_off_w;
    end else begin
      pc_d   = pc_q + 1'b1;
      wrap_d = (pc_q == {A{1'b1}});
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      done_q <= 1'b0;  // Done is a single-cycle pulse
      if (Start) begin
        // Start beats everything, including a Halt in the same cycle.
        state_q   <= RUN;
        pc_q      <= StartAddr;
        running_q <= 1'b1;
        wrapped_q <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            if (Halt) begin
              state_q   <= HALTED;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              pc_q <= pc_d;
              if (wrap_d) begin
                wrapped_q <= 1'b1;
              end
            end
          end
          default: begin
            // IDLE / HALTED: hold everything until Start.
          end
        endcase
      end
    end
  end

  assign InstAddress = pc_q;
  assign Running     = running_q;
  assign Done        = done_q;
  assign Wrapped     = wrapped_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: a table of one-cycle
//            vectors with hand-computed expected outputs, followed by a
//            full wrap-around run and a bounded wait for Done.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [3:0] StartAddr = '0;
  logic       Halt = 1'b0;
  logic       Stall = 1'b0;
  logic       BranchEn = 1'b0;
  logic [3:0] BranchOffset = '0;
  logic       JumpEn = 1'b0;
  logic [2:0] JumpIdx = '0;
  logic [3:0] InstAddress;
  logic       Running;
  logic       Done;
  logic       Wrapped;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Start        (Start),
    .StartAddr    (StartAddr),
    .Halt         (Halt),
    .Stall        (Stall),
    .BranchEn     (BranchEn),
    .BranchOffset (BranchOffset),
    .JumpEn       (JumpEn),
    .JumpIdx      (JumpIdx),
    .InstAddress  (InstAddress),
    .Running      (Running),
    .Done         (Done),
    .Wrapped      (Wrapped)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] saddr;
    logic       halt;
    logic       stall;
    logic       br;
    logic [3:0] off;
    logic       jmp;
    logic [2:0] idx;
    logic [3:0] e_addr;
    logic       e_run;
    logic       e_done;
    logic       e_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic start, input logic [3:0] saddr,
                              input logic halt, input logic stall, input logic br,
                              input logic [3:0] off, input logic jmp, input logic [2:0] idx,
                              input logic [3:0] e_addr, input logic e_run,
                              input logic e_done, input logic e_wrap);
    vec_t v;
    v.rst = rst; v.start = start; v.saddr = saddr; v.halt = halt; v.stall = stall;
    v.br = br; v.off = off; v.jmp = jmp; v.idx = idx;
    v.e_addr = e_addr; v.e_run = e_run; v.e_done = e_done; v.e_wrap = e_wrap;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int vi, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0d expected %0d", name, vi, act, exp);
    end
  endtask

  task automatic drive_idle();
    Reset = 0; Start = 0; StartAddr = 0; Halt = 0; Stall = 0;
    BranchEn = 0; BranchOffset = 0; JumpEn = 0; JumpIdx = 0;
  endtask

  task automatic check_all(input int vi, input logic [3:0] a, input logic r,
                           input logic d, input logic w);
    check("InstAddress", vi, InstAddress, a);
    check("Running", vi, {3'b0, Running}, {3'b0, r});
    check("Done", vi, {3'b0, Done}, {3'b0, d});
    check("Wrapped", vi, {3'b0, Wrapped}, {3'b0, w});
  endtask

  initial begin
    // rst start saddr halt stall br off jmp idx | addr run done wrap
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // reset state
    add(0, 1, 2, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0);  // start at 2
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0,   5, 0, 1, 0);  // halt at 5
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   5, 0, 0, 0);  // Done drops
    add(0, 0, 0, 1, 0, 1, 1, 1, 1,   5, 0, 0, 0);  // decode ignored in HALTED
    add(0, 1, 3, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0);  // restart from HALTED
    add(0, 0, 0, 0, 0, 1, 4'b1110, 0, 0, 1, 1, 0, 0);  // 3 + (-2) = 1
    add(0, 1, 14, 0, 0, 0, 0, 0, 0, 14, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 5, 0, 0,   3, 1, 0, 0);  // 14+5 = 3, no wrap flag
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 3,   6, 1, 0, 0);  // jump beats branch
    add(0, 1, 9, 0, 0, 0, 0, 0, 0,   9, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,   9, 1, 0, 0);  // stall
    add(0, 0, 0, 0, 1, 1, 3, 1, 5,   9, 1, 0, 0);  // stall beats jump/branch
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  10, 1, 0, 0);
    add(0, 1, 15, 0, 0, 0, 0, 0, 0, 15, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);  // increment wraps
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1);  // sticky
    add(0, 0, 0, 1, 1, 0, 0, 0, 0,   1, 0, 1, 1);  // halt beats stall
    add(0, 1, 8, 1, 0, 0, 0, 0, 0,   8, 1, 0, 0);  // start beats halt
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   9, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 7,  14, 1, 0, 0);  // LUT[7] = 14
    add(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0);  // LUT[0] = 0, jump sets no flag
    add(0, 1, 7, 0, 0, 0, 0, 0, 0,   7, 1, 0, 0);
    add(1, 1, 3, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // reset mid-run beats start
    add(0, 0, 0, 0, 0, 1, 3, 1, 2,   0, 0, 0, 0);  // IDLE ignores decode
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      Reset = vecs[i].rst; Start = vecs[i].start; StartAddr = vecs[i].saddr;
      Halt = vecs[i].halt; Stall = vecs[i].stall; BranchEn = vecs[i].br;
      BranchOffset = vecs[i].off; JumpEn = vecs[i].jmp; JumpIdx = vecs[i].idx;
      @(posedge CLK);
      #1;
      check_all(i, vecs[i].e_addr, vecs[i].e_run, vecs[i].e_done, vecs[i].e_wrap);
    end

    // Full lap from 0: wrap flag only after PC passes 15.
    @(negedge CLK);
    drive_idle();
    Start = 1; StartAddr = 0;
    @(posedge CLK); #1;
    check_all(100, 0, 1, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge CLK);
      drive_idle();
      @(posedge CLK); #1;
      check("lap_addr", 100 + k, InstAddress, 4'(k));
      check("lap_wrap", 100 + k, {3'b0, Wrapped}, (k >= 16) ? 4'd1 : 4'd0);
    end

    // Halt and wait, bounded, for the Done pulse.
    @(negedge CLK);
    drive_idle();
    Halt = 1;
    @(negedge CLK);
    drive_idle();
    begin
      int waited = 0;
      while (Done !== 1'b1 && waited < 10) begin
        @(negedge CLK);
        waited++;
      end
      checks++;
      if (Done !== 1'b1) begin
        errors++;
        $display("FAIL done_timeout: got Done=%0b expected 1 within 10 cycles", Done);
      end
    end
    check("halt_addr", 200, InstAddress, 4'd1);
    @(negedge CLK);
    check("done_pulse", 201, {3'b0, Done}, 4'd0);
    check("halt_wrap", 202, {3'b0, Wrapped}, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
